// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  typedef logic [1:0] digit_t;

  // True when digit d is a leading zero that should be hidden: d itself and every higher nibble are zero.
  function automatic logic lz_hidden(input logic [15:0] val, input digit_t d, input logic lz);
    logic zero_above;
    zero_above = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(d) && val[4*i +: 4] != 4'h0) zero_above = 1'b0;
    end
    return lz && (d != 2'd0) && zero_above;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex-to-7-segment decoder, segments {a..g}, active-low.
module hex7seg (
  input  logic [3:0] hex,
  output logic [6:0] a_to_g
);

  always_comb begin
    a_to_g = 7'h7F;
    case (hex)
      4'h0: a_to_g = 7'b0000001;
      4'h1: a_to_g = 7'b1001111;
      4'h2: a_to_g = 7'b0010010;
      4'h3: a_to_g = 7'b0000110;
      4'h4: a_to_g = 7'b1001100;
      4'h5: a_to_g = 7'b0100100;
      4'h6: a_to_g = 7'b0100000;
      4'h7: a_to_g = 7'b0001111;
      4'h8: a_to_g = 7'b0000000;
      4'h9: a_to_g = 7'b0000100;
      4'hA: a_to_g = 7'b0001000;
      4'hB: a_to_g = 7'b1100000;
      4'hC: a_to_g = 7'b0110001;
      4'hD: a_to_g = 7'b1000010;
      4'hE: a_to_g = 7'b0110000;
      4'hF: a_to_g = 7'b0111000;
      default: a_to_g = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit 7-segment scan controller: per-slot blanking, once-per-frame input snapshot,
// leading-zero suppression, all pins driven from registers.
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [15:0] x,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  en,
  input  logic        lz_blank,
  output logic [6:0]  a_to_g,
  output logic        dp,
  output logic [3:0]  an,
  output logic [1:0]  digit_sel,
  output logic        frame_tick
);

  import seg7_pkg::*;

  if (REFRESH_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV ||
      (64'd1 << CNT_W) < 64'(REFRESH_DIV)) begin : g_param_check
    $error("seg7_scan_ctrl: illegal REFRESH_DIV/BLANK_CYCLES/CNT_W combination");
  end

  logic [CNT_W-1:0] cnt, nxt_cnt;
  digit_t           nxt_sel;
  state_t           state, nxt_state;
  logic             started;
  logic             frame_start;
  logic [15:0]      snap_x, use_x;
  logic [3:0]       snap_dp, use_dp, snap_en, use_en;
  logic             snap_lz, use_lz;
  logic [3:0]       nibble;
  logic [6:0]       dec_seg, nxt_seg;
  logic [3:0]       nxt_an;
  logic             nxt_dp;

  hex7seg u_dec (
    .hex    (nibble),
    .a_to_g (dec_seg)
  );

  // Everything below is computed for the cycle about to start, so the pins can be registered
  // and the frame's first cycle already uses the snapshot taken on that same edge.
  always_comb begin
    nxt_cnt = cnt + 1'b1;
    nxt_sel = digit_sel;
    if (!started) begin
      nxt_cnt = '0;
      nxt_sel = 2'd0;
    end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
      nxt_cnt = '0;
      nxt_sel = digit_sel + 2'd1;
    end
    frame_start = (nxt_cnt == '0) && (nxt_sel == 2'd0);
    use_x  = frame_start ? x        : snap_x;
    use_dp = frame_start ? dp_in    : snap_dp;
    use_en = frame_start ? en       : snap_en;
    use_lz = frame_start ? lz_blank : snap_lz;
    nxt_state = (int'(nxt_cnt) < BLANK_CYCLES) ? S_BLANK : S_DRIVE;
    nibble = use_x[{nxt_sel, 2'b00} +: 4];
    nxt_an  = AN_OFF;
    nxt_seg = SEG_BLANK;
    nxt_dp  = 1'b1;
    if (nxt_state == S_DRIVE && use_en[nxt_sel]) begin
      nxt_an  = ~(4'b0001 << nxt_sel);
      nxt_dp  = ~use_dp[nxt_sel];
      nxt_seg = lz_hidden(use_x, nxt_sel, use_lz) ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      started    <= 1'b0;
      cnt        <= '0;
      digit_sel  <= 2'd0;
      state      <= S_BLANK;
      frame_tick <= 1'b0;
      snap_x     <= '0;
      snap_dp    <= '0;
      snap_en    <= '0;
      snap_lz    <= 1'b0;
      an         <= AN_OFF;
      a_to_g     <= SEG_BLANK;
      dp         <= 1'b1;
    end else begin
      started    <= 1'b1;
      cnt        <= nxt_cnt;
      digit_sel  <= nxt_sel;
      state      <= nxt_state;
      frame_tick <= frame_start;
      if (frame_start) begin
        snap_x  <= x;
        snap_dp <= dp_in;
        snap_en <= en;
        snap_lz <= lz_blank;
      end
      an     <= nxt_an;
      a_to_g <= nxt_seg;
      dp     <= nxt_dp;
    end
  end

endmodule
